// File: rtl/bilinear_scheduler.sv
// bilinear_scheduler: issues four diagonal bilinear requests per 3x3 window
// and assembles the 8-point sample ring. Optional macro: SCHED_TIMEOUT_EN.
module bilinear_scheduler #(
  parameter int DW     = 8,
  parameter int TO_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [9*DW-1:0] win,
  input  logic [1:0]      r_in,
  output logic [1:0]      ip_angle,
  output logic [1:0]      ip_r,
  output logic [DW-1:0]   ip_A,
  output logic [DW-1:0]   ip_B,
  output logic [DW-1:0]   ip_C,
  output logic [DW-1:0]   ip_D,
  output logic            ip_issue,
  input  logic [DW-1:0]   ip_I,
  input  logic            ip_z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*DW-1:0] samples,
  output logic [DW-1:0]   center,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  state_t             state_q, state_d;
  logic [9*DW-1:0]    win_q, win_d;
  logic [1:0]         r_q, r_d;
  logic [1:0]         iss_q, iss_d;
  logic [2:0]         res_cnt_q, res_cnt_d;
  logic [3:0][DW-1:0] res_q, res_d;
  logic [DW-1:0]      p [9];
  logic               cap;

  for (genvar k = 0; k < 9; k++) begin : g_pix
    assign p[k] = win_q[DW*k +: DW];
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
`endif

  // Next state, window latch, in-order result capture and WAIT timeout
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    r_d       = r_q;
    iss_d     = iss_q;
    res_cnt_d = res_cnt_q;
    res_d     = res_q;
`ifdef SCHED_TIMEOUT_EN
    to_d      = to_q;
    err_d     = err_q;
`endif
    cap = ip_z && (res_cnt_q < 3'd4) &&
          (state_q == ISSUE || state_q == WAIT);
    if (cap) begin
      res_d[res_cnt_q[1:0]] = ip_I;
      res_cnt_d             = res_cnt_q + 3'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          win_d     = win;
          r_d       = r_in;
          iss_d     = '0;
          res_cnt_d = '0;
          state_d   = ISSUE;
`ifdef SCHED_TIMEOUT_EN
          to_d      = '0;
`endif
        end
      end
      ISSUE: begin
        iss_d = iss_q + 2'd1;
        if (iss_q == 2'd3) state_d = WAIT;
      end
      WAIT: begin
        if (res_cnt_q == 3'd4) begin
          state_d = OUT;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (res_cnt_d != 3'd4) begin
          if (to_q == TW'(TO_CYC - 1)) begin
            err_d     = 1'b1;
            res_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
`endif
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request mux: corners per angle, quiet outside ISSUE
  always_comb begin
    ip_issue = (state_q == ISSUE);
    ip_angle = '0;
    ip_A     = '0;
    ip_B     = '0;
    ip_C     = '0;
    ip_D     = '0;
    if (ip_issue) begin
      ip_angle = iss_q;
      unique case (iss_q)
        2'd0: begin
          ip_A = p[1]; ip_B = p[2];
          ip_C = p[4]; ip_D = p[5];
        end
        2'd1: begin
          ip_A = p[0]; ip_B = p[1];
          ip_C = p[3]; ip_D = p[4];
        end
        2'd2: begin
          ip_A = p[3]; ip_B = p[4];
          ip_C = p[6]; ip_D = p[7];
        end
        default: begin
          ip_A = p[4]; ip_B = p[5];
          ip_C = p[7]; ip_D = p[8];
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      r_q       <= '0;
      iss_q     <= '0;
      res_cnt_q <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      r_q       <= r_d;
      iss_q     <= iss_d;
      res_cnt_q <= res_cnt_d;
      res_q     <= res_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  // Timeout counter and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_to;
  assign unused_to = |TO_CYC;
  assign err       = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign ip_r      = r_q;
  assign center    = p[4];
  assign samples   = {res_q[3], p[7], res_q[2], p[3],
                      res_q[1], p[1], res_q[0], p[5]};

endmodule

// File: tb/tb_bilinear_scheduler.sv
// tb_bilinear_scheduler: random windows against a rule-level sample model,
// with a latency-3 interpolator responder and fault-injection knobs.
module tb_bilinear_scheduler;
  localparam int DW     = 8;
  localparam int TO_CYC = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [9*DW-1:0] win = '0;
  logic [1:0]      r_in = '0;
  logic [1:0]      ip_angle, ip_r;
  logic [DW-1:0]   ip_A, ip_B, ip_C, ip_D;
  logic            ip_issue;
  logic [DW-1:0]   ip_I;
  logic            ip_z;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [8*DW-1:0] samples;
  logic [DW-1:0]   center;
  logic            err;

  always #5 clk = ~clk;

  bilinear_scheduler #(.DW(DW), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .win(win), .r_in(r_in),
    .ip_angle(ip_angle), .ip_r(ip_r),
    .ip_A(ip_A), .ip_B(ip_B), .ip_C(ip_C), .ip_D(ip_D),
    .ip_issue(ip_issue), .ip_I(ip_I), .ip_z(ip_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .samples(samples), .center(center), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // corner pixel indices (A,B,C,D) for angles NE, NW, SW, SE
  int cidx [4][4] = '{'{1, 2, 4, 5}, '{0, 1, 3, 4},
                      '{3, 4, 6, 7}, '{4, 5, 7, 8}};

  logic [DW-1:0] pix  [9];
  logic [DW-1:0] pix2 [9];
  logic [63:0]   last_s = '0;

  // responder knobs and issue log
  int          drop_ang = -1;
  bit          extra_en = 1'b0;
  bit          spur = 1'b0;
  int          z_seen = 0;
  logic [1:0]  lg_ang [$];
  logic [1:0]  lg_r [$];
  logic [31:0] lg_abcd [$];

  // interpolator model: returns ip_A three cycles after each issue
  bit            pv [3];
  logic [DW-1:0] pd [3];
  logic [1:0]    pa [3];
  bit            pend_x;
  logic [DW-1:0] xd;
  initial begin
    ip_z = 1'b0;
    ip_I = '0;
    pend_x = 1'b0;
    xd = '0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; pd[i] = '0; pa[i] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      ip_z = 1'b0;
      ip_I = '0;
      if (pend_x) begin
        ip_z = 1'b1; ip_I = xd; pend_x = 1'b0;
      end else if (pv[2] && int'(pa[2]) != drop_ang) begin
        ip_z = 1'b1; ip_I = pd[2]; z_seen++;
        if (extra_en && pa[2] == 2'd3) begin
          pend_x = 1'b1; xd = ~pd[2];
        end
      end
      if (spur) begin
        ip_z = 1'b1; ip_I = DW'($urandom);
      end
      for (int i = 2; i > 0; i--) begin
        pv[i] = pv[i-1]; pd[i] = pd[i-1]; pa[i] = pa[i-1];
      end
      pv[0] = ip_issue; pd[0] = ip_A; pa[0] = ip_angle;
      if (ip_issue) begin
        lg_ang.push_back(ip_angle);
        lg_r.push_back(ip_r);
        lg_abcd.push_back({ip_A, ip_B, ip_C, ip_D});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [9*DW-1:0] pack_win(input logic [DW-1:0] px [9]);
    logic [9*DW-1:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[DW*k +: DW] = px[k];
    return v;
  endfunction

  // s0/s2/s4/s6 are the E/N/W/S pixels; odd slots hold corner A per angle
  function automatic logic [63:0] model_s();
    logic [DW-1:0] s [8];
    logic [63:0]   v;
    s[0] = pix[5]; s[2] = pix[1]; s[4] = pix[3]; s[6] = pix[7];
    for (int a = 0; a < 4; a++) s[2*a+1] = pix[cidx[a][0]];
    v = '0;
    for (int k = 0; k < 8; k++) v[DW*k +: DW] = s[k];
    return v;
  endfunction

  task automatic rand_pix();
    for (int k = 0; k < 9; k++) pix[k] = DW'($urandom);
  endtask

  task automatic do_window(input logic [1:0] r, input int stall,
                           input bit hold_next);
    int n;
    int bad;
    logic [63:0] exp;
    bad = 0;
    win = pack_win(pix);
    r_in = r;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick(); n++;
    end
    lg_ang.delete(); lg_r.delete(); lg_abcd.delete();
    tick();
    if (in_ready) bad++;
    in_valid = hold_next;
    if (hold_next) win = pack_win(pix2);
    exp = model_s();
    n = 0;
    while (!out_valid && n < 200) begin
      tick(); n++;
      if (in_ready) bad++;
      if (!ip_issue && ({ip_angle, ip_A, ip_B, ip_C, ip_D} != '0)) bad++;
    end
    chk("latency", 64'(n), 64'd8);
    chk("samples", samples, exp);
    chk("center", center, pix[4]);
    chk("n_issue", 64'(lg_ang.size()), 64'd4);
    for (int k = 0; k < lg_ang.size() && k < 4; k++)
      chk("issue", {lg_ang[k], lg_r[k], lg_abcd[k]},
          {2'(k), r, pix[cidx[k][0]], pix[cidx[k][1]],
           pix[cidx[k][2]], pix[cidx[k][3]]});
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      tick();
      if (!out_valid || in_ready || samples !== exp) bad++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handshake", {in_ready, out_valid}, 2'b10);
    chk("busy_rules", 64'(bad), 64'd0);
    last_s = exp;
  endtask

  initial begin
    int n;
    int zb;
    bit seen_ov;
    #1;
    chk("rst_ctl", {in_ready, out_valid, ip_issue, err}, 4'b1000);
    chk("rst_samples", samples, 64'd0);
    chk("rst_center", center, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // directed window 1..9, radius 3, five stalled cycles
    for (int k = 0; k < 9; k++) pix[k] = DW'(k + 1);
    do_window(2'd3, 5, 1'b0);

    // spurious ip_z in IDLE, then a window with a 5th ip_z in WAIT
    spur = 1'b1; tick(); tick(); spur = 1'b0; tick();
    chk("spur_idle", samples, last_s);
    extra_en = 1'b1;
    rand_pix();
    do_window(2'd1, 0, 1'b0);
    extra_en = 1'b0;
    tick(); tick();
    chk("extra_z", samples, last_s);

    // two windows with in_valid held high
    rand_pix();
    for (int k = 0; k < 9; k++) pix2[k] = DW'($urandom);
    do_window(2'd2, 1, 1'b1);
    pix = pix2;
    do_window(2'd0, 0, 1'b0);

    // random windows
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        spur = 1'b1; tick(); spur = 1'b0; tick();
        chk("spur_rand", samples, last_s);
      end
      extra_en = ($urandom_range(0, 1) == 1);
      rand_pix();
      do_window(2'($urandom), int'($urandom_range(0, 3)), 1'b0);
      extra_en = 1'b0;
    end

    // reset during WAIT after two results
    rand_pix();
    win = pack_win(pix);
    r_in = 2'd2;
    in_valid = 1'b1;
    zb = z_seen;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (z_seen < zb + 2 && n < 50) begin
      tick(); n++;
    end
    chk("rst_wait_z", 64'(z_seen - zb), 64'd2);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_ctl", {in_ready, out_valid, ip_issue, err}, 4'b1000);
    chk("rst_mid_samples", samples, 64'd0);
    chk("rst_mid_center", center, 0);
    #1;
    rst = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    chk("rst_late_z", samples, 64'd0);
    chk("rst_late_ov", 64'(seen_ov), 64'd0);
    rand_pix();
    do_window(2'd1, 0, 1'b0);

    // dropped fourth result
    drop_ang = 3;
    rand_pix();
    win = pack_win(pix);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n = 0;
    seen_ov = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    while (!in_ready && n < 100) begin
      tick(); n++;
      if (out_valid) seen_ov = 1'b1;
    end
    chk("to_cycles", 64'(n), 64'(TO_CYC));
    chk("to_err", err, 1'b1);
    chk("to_no_ov", 64'(seen_ov), 64'd0);
    drop_ang = -1;
    for (int i = 0; i < 4; i++) tick();
    rand_pix();
    do_window(2'd3, 0, 1'b0);
    chk("err_sticky", err, 1'b1);
`else
    while (n < 40) begin
      tick(); n++;
      if (out_valid) seen_ov = 1'b1;
    end
    chk("wait_forever", {in_ready, err}, 2'b00);
    chk("wait_no_ov", 64'(seen_ov), 64'd0);
    drop_ang = -1;
`endif
    rst = 1'b0;
    #1;
    chk("rst_final", {in_ready, out_valid, err}, 3'b100);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rand_pix();
    do_window(2'd2, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
